// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported 64-bit memory between instruction fetch and data access,
// with data priority, a starvation guard for fetches, and pipeline stall outputs.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_ready,
    output logic [63:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              pipe_stall,
    output logic              grant_d
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [3:0]        LP_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LP_ALIGN = {{(ADDR_W-3){1'b1}}, 3'b000};

    state_t            r_state;
    logic [3:0]        r_starve_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_mem_wdata;
    logic              r_grant_d;
    logic              r_if_ready;
    logic              r_d_ready;
    logic [31:0]       r_if_rdata;
    logic [63:0]       r_d_rdata;
    logic              w_pick_d;

    // Data wins unless a waiting fetch has already been passed over STARVE_LIMIT times.
    assign w_pick_d = d_req && !(if_req && (r_starve_cnt == LP_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_addr       <= '0;
            r_mem_wdata  <= '0;
            r_grant_d    <= 1'b0;
            r_if_ready   <= 1'b0;
            r_d_ready    <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_d) begin
                        r_addr       <= d_addr;
                        r_mem_we     <= d_we;
                        r_mem_wdata  <= d_wdata;
                        r_grant_d    <= 1'b1;
                        r_mem_req    <= 1'b1;
                        r_starve_cnt <= if_req ? r_starve_cnt + 4'd1 : '0;
                        r_state      <= S_BUSY;
                    end else if (if_req) begin
                        r_addr       <= if_addr;
                        r_mem_we     <= 1'b0;
                        r_grant_d    <= 1'b0;
                        r_mem_req    <= 1'b1;
                        r_starve_cnt <= '0;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_grant_d) begin
                            if (!r_mem_we) begin
                                r_d_rdata <= mem_rdata;
                            end
                            r_d_ready <= 1'b1;
                        end else begin
                            // Full fetch address is kept so bit 2 selects the instruction word.
                            r_if_rdata <= r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                            r_if_ready <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_if_ready <= 1'b0;
                    r_d_ready  <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_addr & LP_ALIGN;
    assign mem_wdata   = r_mem_wdata;
    assign grant_d     = r_grant_d;
    assign if_ready    = r_if_ready;
    assign d_ready     = r_d_ready;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign pc_write    = ~(if_req & ~r_if_ready);
    assign if_id_write = ~(if_req & ~r_if_ready);
    assign pipe_stall  = d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses and memory commands are queued
// at stimulus time and popped by independent monitors.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [63:0]   d_wdata;
    logic          d_ready;
    logic [63:0]   d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata;
    logic          mem_ready;
    logic          pc_write;
    logic          if_id_write;
    logic          pipe_stall;
    logic          grant_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .pipe_stall(pipe_stall),
        .grant_d(grant_d)
    );

    typedef struct {
        logic        is_d;
        logic [63:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [63:0] wdata;
    } cmd_t;

    resp_t       exp_resp[$];
    cmd_t        exp_cmd[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] mem [0:63];
    int          mem_wait = 0;
    bit          mem_manual = 1'b0;

    localparam logic [63:0] W_FETCH = 64'h00A00093_00300113;
    localparam logic [63:0] W_LOAD  = 64'h11223344_55667788;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a);
        bit seen = 1'b0;
        if_addr = a;
        if_req  = 1'b1;
        for (int n = 0; n < 60; n++) begin
            next_cycle();
            if (if_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("if_ready_seen", {63'b0, seen}, 64'd1);
        next_cycle();
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [AW-1:0] a, input logic [63:0] wd);
        bit seen = 1'b0;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        for (int n = 0; n < 60; n++) begin
            next_cycle();
            if (d_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("d_ready_seen", {63'b0, seen}, 64'd1);
        next_cycle();
        d_req = 1'b0;
    endtask

    // Response monitor
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (if_ready === 1'b1 || d_ready === 1'b1) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: if_ready=%b d_ready=%b required none at %0t",
                             if_ready, d_ready, $time);
                end else begin
                    e = exp_resp.pop_front();
                    chk("resp_is_d", {63'b0, d_ready}, {63'b0, e.is_d});
                    chk("resp_is_if", {63'b0, if_ready}, {63'b0, ~e.is_d});
                    if (e.is_d) chk("d_rdata", d_rdata, e.data);
                    else        chk("if_rdata", {32'b0, if_rdata}, e.data);
                end
            end
        end
    end

    // Memory model and command monitor
    initial begin
        cmd_t     c;
        logic     prev_req = 1'b0;
        int       wcnt = 0;
        logic [5:0] idx;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            next_cycle();
            if (mem_req && !prev_req) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: mem_addr=%h required none at %0t", mem_addr, $time);
                end else begin
                    c = exp_cmd.pop_front();
                    chk("mem_addr", {32'b0, mem_addr}, {32'b0, c.addr});
                    chk("mem_we", {63'b0, mem_we}, {63'b0, c.we});
                    if (c.we) chk("mem_wdata", mem_wdata, c.wdata);
                end
            end
            prev_req = mem_req;
            if (!mem_manual) begin
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    wcnt = 0;
                end else if (mem_req) begin
                    if (wcnt == mem_wait) begin
                        idx       = mem_addr[8:3];
                        mem_rdata = mem[idx];
                        if (mem_we) mem[idx] = mem_wdata;
                        mem_ready = 1'b1;
                        wcnt      = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
        mem[0]  = W_FETCH;
        mem[32] = W_LOAD;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {63'b0, mem_req}, 0);
        chk("rst_mem_we", {63'b0, mem_we}, 0);
        chk("rst_grant_d", {63'b0, grant_d}, 0);
        chk("rst_if_ready", {63'b0, if_ready}, 0);
        chk("rst_d_ready", {63'b0, d_ready}, 0);
        chk("rst_mem_addr", {32'b0, mem_addr}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", {32'b0, if_rdata}, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_pc_write", {63'b0, pc_write}, 1);
        chk("rst_if_id_write", {63'b0, if_id_write}, 1);
        chk("rst_pipe_stall", {63'b0, pipe_stall}, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Isolated fetch, upper word selected by address bit 2
        exp_cmd.push_back('{32'h0, 1'b0, 64'h0});
        exp_resp.push_back('{1'b0, 64'h00A00093});
        fork
            do_fetch(32'h4);
            begin
                @(negedge clk);
                chk("f_pc_write_c0", {63'b0, pc_write}, 0);
                chk("f_if_id_write_c0", {63'b0, if_id_write}, 0);
                chk("f_mem_req_c0", {63'b0, mem_req}, 0);
                @(negedge clk);
                chk("f_pc_write_c1", {63'b0, pc_write}, 0);
                chk("f_mem_req_c1", {63'b0, mem_req}, 1);
                chk("f_grant_d_c1", {63'b0, grant_d}, 0);
                @(negedge clk);
                chk("f_pc_write_c2", {63'b0, pc_write}, 1);
                chk("f_if_ready_c2", {63'b0, if_ready}, 1);
                chk("f_mem_req_c2", {63'b0, mem_req}, 0);
            end
        join

        // Load with two memory wait cycles
        mem_wait = 2;
        exp_cmd.push_back('{32'h100, 1'b0, 64'h0});
        exp_resp.push_back('{1'b1, W_LOAD});
        fork
            do_data(1'b0, 32'h100, 64'h0);
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("ld_pipe_stall", {63'b0, pipe_stall}, 1);
                    if (c > 0) chk("ld_mem_req", {63'b0, mem_req}, 1);
                end
                @(negedge clk);
                chk("ld_d_ready_c4", {63'b0, d_ready}, 1);
                chk("ld_pipe_stall_c4", {63'b0, pipe_stall}, 0);
            end
        join
        mem_wait = 0;

        // Store: read data register must keep the previous load value
        exp_cmd.push_back('{32'h108, 1'b1, 64'h1});
        exp_resp.push_back('{1'b1, W_LOAD});
        fork
            do_data(1'b1, 32'h108, 64'h1);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("st_mem_we_c1", {63'b0, mem_we}, 1);
                chk("st_mem_wdata_c1", mem_wdata, 64'h1);
                @(negedge clk);
                chk("st_mem_we_c2", {63'b0, mem_we}, 0);
            end
        join

        // Unaligned load of the stored doubleword
        exp_cmd.push_back('{32'h108, 1'b0, 64'h0});
        exp_resp.push_back('{1'b1, 64'h1});
        do_data(1'b0, 32'h10C, 64'h0);

        // Simultaneous requests: data first, fetch re-arbitrated in cycle 3
        exp_cmd.push_back('{32'h100, 1'b0, 64'h0});
        exp_cmd.push_back('{32'h0, 1'b0, 64'h0});
        exp_resp.push_back('{1'b1, W_LOAD});
        exp_resp.push_back('{1'b0, 64'h00300113});
        fork
            do_data(1'b0, 32'h100, 64'h0);
            do_fetch(32'h0);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("sim_grant_d_c1", {63'b0, grant_d}, 1);
                repeat (3) @(negedge clk);
                chk("sim_grant_d_c4", {63'b0, grant_d}, 0);
                chk("sim_mem_req_c4", {63'b0, mem_req}, 1);
                @(negedge clk);
                chk("sim_if_ready_c5", {63'b0, if_ready}, 1);
            end
        join

        // Starvation: both held high; fetch every fifth grant, counter restarts after it
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) begin
                exp_cmd.push_back('{32'h0, 1'b0, 64'h0});
                exp_resp.push_back('{1'b0, 64'h00300113});
            end else begin
                exp_cmd.push_back('{32'h100, 1'b0, 64'h0});
                exp_resp.push_back('{1'b1, W_LOAD});
            end
        end
        d_we = 1'b0; d_addr = 32'h100; if_addr = 32'h0;
        d_req = 1'b1; if_req = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            next_cycle();
            if (if_ready || d_ready) n++;
        end
        chk("starve_resp_count", 64'(n), 64'd10);
        next_cycle();
        d_req = 1'b0; if_req = 1'b0;
        repeat (2) next_cycle();

        // Reset during BUSY drops the transaction; late mem_ready is ignored
        mem_manual = 1'b1;
        exp_cmd.push_back('{32'h100, 1'b0, 64'h0});
        d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rb_mem_req_c1", {63'b0, mem_req}, 1);
        next_cycle();
        reset = 1'b1; d_req = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rb_mem_req_c3", {63'b0, mem_req}, 0);
        chk("rb_d_ready_c3", {63'b0, d_ready}, 0);
        chk("rb_grant_d_c3", {63'b0, grant_d}, 0);
        next_cycle();
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        next_cycle();
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rb_mem_req_after", {63'b0, mem_req}, 0);
            chk("rb_d_ready_after", {63'b0, d_ready}, 0);
            chk("rb_d_rdata_after", d_rdata, 64'h0);
        end
        mem_manual = 1'b0;
        next_cycle();

        // Arbiter still serves normally after the dropped transaction
        exp_cmd.push_back('{32'h0, 1'b0, 64'h0});
        exp_resp.push_back('{1'b0, 64'h00300113});
        do_fetch(32'h0);

        repeat (3) next_cycle();
        chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
        chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, 64-bit-wide unified memory between the pipelined processor's instruction-fetch (IF) stage and its data-access (MEM) stage. It runs one memory transaction at a time, grants data accesses over fetches with a bounded starvation guard, and returns response pulses to each requester. It also drives the pipeline stall controls: `pc_write` and `if_id_write` toward IF, and `pipe_stall` toward the whole pipeline. It sits between the processor core and the memory model used by the processor testbench.

## Interface
- `ADDR_W`, 32: byte-address width for both requesters and for the memory.
- `STARVE_LIMIT`, 4: maximum number of consecutive data grants while a fetch is waiting. Legal range is 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_ready`.
- `if_addr`  in  ADDR_W  fetch byte address, held stable while `if_req` is high.
- `if_ready`  out  1  one-cycle fetch-complete pulse.
- `if_rdata`  out  32  fetched instruction.
- `d_req`  in  1  data request; held high until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load; held stable with `d_req`.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  64  store data.
- `d_ready`  out  1  one-cycle data-complete pulse.
- `d_rdata`  out  64  load data.
- `mem_req`  out  1  memory request; held high until `mem_ready`.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  8-byte-aligned memory address.
- `mem_wdata`  out  64  memory write data.
- `mem_rdata`  in  64  memory read data; valid in the cycle `mem_ready` is high.
- `mem_ready`  in  1  memory completion; sampled only in state BUSY.
- `pc_write`  out  1  PC update enable.
- `if_id_write`  out  1  IF/ID register update enable.
- `pipe_stall`  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- `grant_d`  out  1  the owner of the current transaction (1 = data, 0 = fetch).

## Operation
The arbiter is a three-state FSM: IDLE, BUSY, RESP.

- **IDLE**
  - If either request is high, latch the winner's command into the `mem_*` registers.
  - Set `mem_req` = 1 and `grant_d` to the winner, then go to BUSY.
  - If neither request is high, stay in IDLE.
- **Arbitration**
  - `d_req` wins over `if_req`.
  - Exception: when `starve_cnt` == `STARVE_LIMIT` and `if_req` is high, the fetch wins.
- **Starvation counter** (`starve_cnt`, 4 bits, updated at each grant)
  - Data granted while `if_req` is high: increment.
  - Fetch granted, or data granted while `if_req` is low: clear to 0.
- **Fetch command**
  - `mem_addr` = `if_addr` with bits [2:0] forced to 0.
  - `mem_we` = 0.
- **Data command**
  - `mem_addr` = `d_addr` with bits [2:0] forced to 0.
  - `mem_we` = `d_we`, `mem_wdata` = `d_wdata`.
- **BUSY**
  - `mem_req` stays high and the command is held constant.
  - On `mem_ready`: clear `mem_req` and `mem_we`, capture read data, go to RESP.
  - For a fetch, capture `if_rdata` = `mem_rdata[63:32]` when `if_addr[2]` = 1, otherwise `mem_rdata[31:0]`.
  - For a data load, capture `d_rdata` = `mem_rdata`.
  - For a store, `d_rdata` keeps its previous value.
- **RESP**
  - Pulse `if_ready` or `d_ready` (matching `grant_d`) for exactly one cycle, then go to IDLE.
- **Stall outputs** (combinational from registered state)
  - `pc_write` = `if_id_write` = ~(`if_req` & ~`if_ready`).
  - `pipe_stall` = `d_req` & ~`d_ready`.
- **Ignored inputs**
  - `mem_ready` outside BUSY is ignored.
  - A requester dropping its request early is a protocol violation; the arbiter still completes the transaction and pulses ready.

## Timing
- Reset values:
  - state = IDLE, `starve_cnt` = 0.
  - `mem_req`, `mem_we`, `grant_d`, `if_ready`, `d_ready` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - `pc_write` and `if_id_write` follow their equations: 1 when `if_req` is low.
- Latency: request high in cycle 0 gives `mem_req` in cycle 1.
  - A zero-wait memory (`mem_ready` in cycle 1) gives the ready pulse in cycle 2.
  - Each memory wait cycle adds one cycle.
- Throughput: at most one transaction per 3 cycles, since RESP→IDLE→BUSY.
- A request still high in RESP is re-arbitrated in the following IDLE cycle. The requester must drop `req` in the cycle after its ready pulse or it is served again.
- Simultaneous `if_req` and `d_req` in IDLE: data wins unless `starve_cnt` == `STARVE_LIMIT`.
- Reset during BUSY or RESP:
  - Next cycle: IDLE, `mem_req` = 0, no ready pulse; the outstanding transaction is dropped.
  - A `mem_ready` arriving afterward is ignored.

## Test plan
- **Isolated fetch:** `if_req`=1, `if_addr`=0x0004, zero-wait memory returning `mem_rdata`=0x00A00093_00300113.
  - `mem_req` high in cycle 1 with `mem_addr`=0x0000.
  - `if_ready` pulse in cycle 2 with `if_rdata`=0x00A00093.
  - `pc_write`=0 in cycles 0–1 and 1 in cycle 2.
- **Load with 2 wait cycles:** `d_req`=1, `d_we`=0, `d_addr`=0x0100, `mem_ready` in cycle 3.
  - `d_ready` in cycle 4 with `d_rdata`=`mem_rdata`.
  - `pipe_stall`=1 in cycles 0–3.
- **Simultaneous requests:** `if_req` and `d_req` both high in cycle 0.
  - Data is granted first (`grant_d`=1).
  - Fetch is granted in cycle 3, with `if_ready` in cycle 5.
- **Starvation:** `d_req` held high continuously with `if_req` high, `STARVE_LIMIT`=4.
  - The first four grants go to data; the fifth goes to fetch.
  - `starve_cnt` is back at 0 after the fetch grant.
- **Store:** `d_we`=1, `d_addr`=0x0108, `d_wdata`=0x1.
  - `mem_we`=1 and `mem_wdata`=0x1 while `mem_req` is high.
  - `d_ready` pulses; `d_rdata` is unchanged.
- **Reset in BUSY:** assert `reset` in cycle 2 of a 4-wait load.
  - Cycle 3: `mem_req`=0, no `d_ready`.
  - `mem_ready` in cycle 5 is ignored and the FSM stays in IDLE.
